// File: rtl/regfile_onehot32.sv
// 32 x WIDTH register file fed by a one-hot write-select vector, with two combinational read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module regfile_onehot32 #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      wrSel,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam logic [4:0] ZREG = 5'(ZERO_REG);

  logic [31:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]       rd1_p0;
  logic [WIDTH-1:0]       rd2_p0;

  // 32:1 read select built as an 8:1 stage on the low index bits, then a 4:1 stage.
  function automatic logic [WIDTH-1:0] read_mux(input logic [31:0][WIDTH-1:0] r,
                                                input logic [4:0]              a);
    logic [3:0][WIDTH-1:0] oct;
    logic [1:0]            grp;
    for (int g = 0; g < 4; g++) begin
      grp    = 2'(g);
      oct[g] = r[{grp, a[2:0]}];
    end
    return oct[a[4:3]];
  endfunction

  // Storage: each writable entry is its own load-enabled bank; writes are not prioritised,
  // so a multi-hot select loads the same data into every selected entry.
  for (genvar i = 0; i < 32; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      logic sel_unused;
      assign sel_unused = wrSel[i];
      assign regs[i]    = '0;
    end else begin : g_ff
      logic [WIDTH-1:0] q_p0;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_p0 <= '0;
        end else if (wrSel[i]) begin
          q_p0 <= WriteData;
        end
      end
      assign regs[i] = q_p0;
    end
  end

  assign rd1_p0 = read_mux(regs, ReadRegister1);
  assign rd2_p0 = read_mux(regs, ReadRegister2);

`ifdef REGFILE_WRITE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  assign fwd1      = !reset && wrSel[ReadRegister1] && (ReadRegister1 != ZREG);
  assign fwd2      = !reset && wrSel[ReadRegister2] && (ReadRegister2 != ZREG);
  assign ReadData1 = fwd1 ? WriteData : rd1_p0;
  assign ReadData2 = fwd2 ? WriteData : rd2_p0;
`else
  logic [4:0] zreg_unused;
  assign zreg_unused = ZREG;
  assign ReadData1   = rd1_p0;
  assign ReadData2   = rd2_p0;
`endif

endmodule

// File: tb/tb_regfile_onehot32.sv
// Scoreboard bench for regfile_onehot32: expected read data is queued when addresses are driven
// and compared once the combinational outputs settle.
module tb_regfile_onehot32;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   wrSel = '0;
  logic [W-1:0]  WriteData = '0;
  logic [4:0]    ReadRegister1 = '0;
  logic [4:0]    ReadRegister2 = '0;
  logic [W-1:0]  ReadData1;
  logic [W-1:0]  ReadData2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    int           port;
    logic [W-1:0] v;
  } sb_t;

  sb_t          sb[$];
  logic [W-1:0] model [32];

  regfile_onehot32 #(.WIDTH(W), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .wrSel         (wrSel),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  // Reference storage: async clear, register 31 never written.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) model[k] <= '0;
    end else begin
      for (int k = 0; k < 31; k++) if (wrSel[k]) model[k] <= WriteData;
    end
  end

  initial for (int k = 0; k < 32; k++) model[k] = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] expv(input logic [4:0] a);
    if (reset || a == 5'd31) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wrSel[a]) return WriteData;
`endif
    return model[a];
  endfunction

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    sb_t e;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    sb.push_back('{$sformatf("%s_p1_r%0d", tag, a1), 1, expv(a1)});
    sb.push_back('{$sformatf("%s_p2_r%0d", tag, a2), 2, expv(a2)});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, (e.port == 1) ? ReadData1 : ReadData2, e.v);
    end
  endtask

  task automatic wr(input logic [31:0] sel, input logic [W-1:0] data);
    @(negedge clk);
    wrSel     = sel;
    WriteData = data;
    @(posedge clk);
    #1;
    wrSel = '0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) rd(5'(a), 5'(31 - a), "rst_init");
    @(negedge clk);
    reset = 1'b0;

    wr(32'h0000_0020, 64'hDEAD_BEEF_0123_4567);
    rd(5'd5, 5'd5, "basic");

    for (int i = 0; i < 32; i++) wr(32'd1 << i, 64'(i) * 64'h0101_0101_0101_0101);
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(i), "sweep");
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(30 - i), "sweep_x");

    wr(32'h8000_0000, '1);
    rd(5'd31, 5'd31, "zero_reg");

    wr(32'h0, 64'hFFFF_0000_FFFF_0000);
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(i), "no_write");

    wr(32'h0000_0300, 64'h0BAD_CAFE_0000_0042);
    rd(5'd8, 5'd9, "multihot");
    rd(5'd10, 5'd7, "multihot_nbr");

    wr(32'd1 << 7, 64'h1111);
    @(negedge clk);
    wrSel     = 32'd1 << 7;
    WriteData = 64'h2222;
    rd(5'd7, 5'd7, "same_cyc_pre");
    @(posedge clk);
    #1;
    wrSel = '0;
    rd(5'd7, 5'd7, "same_cyc_post");

    wr(32'd1 << 3, 64'hAAAA);
    rd(5'd3, 5'd3, "mid_pre");
    @(negedge clk);
    wrSel     = 32'd1 << 3;
    WriteData = 64'hBBBB;
    #1 reset = 1'b1;
    rd(5'd3, 5'd3, "mid_rst_now");
    for (int a = 0; a < 32; a++) rd(5'(a), 5'(a), "mid_rst_all");
    @(posedge clk);
    #1;
    rd(5'd3, 5'd3, "mid_rst_edge");
    @(negedge clk);
    reset = 1'b0;
    rd(5'd3, 5'd3, "rel_pre");
    @(posedge clk);
    #1;
    wrSel = '0;
    rd(5'd3, 5'd3, "rel_post");
    rd(5'd7, 5'd5, "rel_other");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
